// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin share of one UART transmitter among NUM_REQ byte producers.
// Latency : valid seen in IDLE at edge t -> tx_en/req_ready pulse in cycle t+1.
// Backpr. : no grant while tx_busy=1 or a frame is in flight; requesters hold valid until req_ready.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   req_valid/req_data   per-requester byte pending; byte i at req_data[8*i+7:8*i]
//   req_ready            one-hot 1-cycle accept pulse
//   tx_en/tx_data        start pulse and byte to the transmitter
//   tx_busy              transmitter frame in progress
//   grant_id             current/last granted requester
//   arb_busy             sequencer not idle
//   done / timeout_err   1-cycle completion / no-busy-rise pulses (exclusive)
module uart_tx_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int BUSY_TIMEOUT = 1024,
  localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW           = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_en,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [GW-1:0]          grant_id,
  output logic                   arb_busy,
  output logic                   done,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [CW-1:0]   busy_cnt;

  logic            found;
  logic [GW-1:0]   pick;
  logic [GW-1:0]   idx;
  logic [7:0]      pick_data;

  // Rotating priority: scan last_grant+1, +2, ... and take the first valid.
  always_comb begin
    found     = 1'b0;
    pick      = last_grant;
    idx       = '0;
    pick_data = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (GW'(j) == pick) pick_data = req_data[8*j +: 8];
    end
  end

  assign arb_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      last_grant  <= GW'(NUM_REQ - 1);
      busy_cnt    <= '0;
    end else begin
      // All pulse outputs default low; each is raised for exactly one cycle.
      req_ready   <= '0;
      tx_en       <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found && !tx_busy) begin
            tx_data   <= pick_data;
            grant_id  <= pick;
            req_ready <= NUM_REQ'(1) << pick;
            tx_en     <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == CW'(BUSY_TIMEOUT - 1)) begin
            // This is the BUSY_TIMEOUT-th cycle without a busy rise.
            timeout_err <= 1'b1;
            last_grant  <= grant_id;
            state       <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            done       <= 1'b1;
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose : directed self-checking bench for uart_tx_arbiter with a behavioural UART stub.
// Latency : stub raises busy the cycle it sees tx_en; frame is 10 bits of BAUD clocks.
// Backpr. : stub can be disabled (busy never rises) or busy forced high.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int BT      = 1024;
  localparam int BAUD    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        arb_busy;
  logic        done;
  logic        timeout_err;

  logic        stub_en;
  logic        force_busy;
  logic        sbusy;
  logic        serial;
  logic [9:0]  frame;
  int          div;
  int          nbits;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .arb_busy(arb_busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign tx_busy = sbusy | force_busy;

  // Behavioural transmitter: start bit, 8 data bits LSB first, stop bit.
  initial begin
    sbusy  = 1'b0;
    serial = 1'b1;
    frame  = '1;
    div    = 0;
    nbits  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!sbusy) begin
        if (stub_en && tx_en) begin
          frame  = {1'b1, tx_data, 1'b0};
          sbusy  = 1'b1;
          div    = 0;
          nbits  = 0;
          serial = 1'b0;
        end
      end else begin
        div++;
        if (div == BAUD) begin
          div   = 0;
          frame = frame >> 1;
          nbits++;
          if (nbits == 10) begin
            sbusy  = 1'b0;
            serial = 1'b1;
          end else begin
            serial = frame[0];
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // which: 0=tx_en 1=done 2=timeout_err. Counts other pulses seen on the way.
  task automatic wait_event(input int which, input int max_cyc, output bit ok,
                            output int ntx, output int ndone, output int ncyc);
    ok = 1'b0; ntx = 0; ndone = 0; ncyc = 0;
    while (!ok && ncyc < max_cyc) begin
      @(negedge clk);
      ncyc++;
      case (which)
        0:       ok = (tx_en === 1'b1);
        1:       ok = (done === 1'b1);
        default: ok = (timeout_err === 1'b1);
      endcase
      if (!ok && tx_en === 1'b1) ntx++;
      if (!ok && done === 1'b1) ndone++;
    end
  endtask

  task automatic test_reset_single();
    bit ok; int ntx, nd, nc;
    req_valid = '0; req_data = '0;
    do_reset();
    checks++;
    if ({req_ready, tx_en, tx_data, grant_id, done, timeout_err, arb_busy} !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b en=%b data=%h gid=%0d done=%b to=%b busy=%b required all 0",
               req_ready, tx_en, tx_data, grant_id, done, timeout_err, arb_busy);
    end
    req_data[7:0] = 8'hA5;
    req_valid     = 4'b0001;
    @(negedge clk);
    checks++;
    if (tx_en !== 1'b1 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL single_launch: en=%b rdy=%b required 1/0001", tx_en, req_ready);
    end
    checks++;
    if (tx_data !== 8'hA5 || grant_id !== 2'd0 || arb_busy !== 1'b1) begin
      errors++; $display("FAIL single_data: data=%h gid=%0d busy=%b required A5/0/1", tx_data, grant_id, arb_busy);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (tx_en !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL single_pulse_width: en=%b rdy=%b required 0/0000", tx_en, req_ready);
    end
    wait_event(1, 200, ok, ntx, nd, nc);
    checks++;
    if (ok !== 1'b1 || ntx !== 0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL single_done: seen=%b extra_tx=%0d gid=%0d required 1/0/0", ok, ntx, grant_id);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: done=%b required 0", done);
    end
  endtask

  task automatic test_all_four();
    bit ok; int ntx, nd, nc;
    logic [3:0] exp_rdy;
    logic [7:0] exp_dat;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_valid = 4'b1111;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      exp_rdy = 4'b0001 << k;
      exp_dat = 8'hA0 + 8'(k);
      wait_event(0, 200, ok, ntx, nd, nc);
      checks++;
      if (ok !== 1'b1 || grant_id !== 2'(k) || tx_data !== exp_dat || req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL all4_grant%0d: seen=%b gid=%0d data=%h rdy=%b required 1/%0d/%h/%b",
                 k, ok, grant_id, tx_data, req_ready, k, exp_dat, exp_rdy);
      end
      req_valid[k] = 1'b0;
      wait_event(1, 200, ok, ntx, nd, nc);
      checks++;
      if (ok !== 1'b1 || ntx !== 0) begin
        errors++; $display("FAIL all4_done%0d: seen=%b tx_before_done=%0d required 1/0", k, ok, ntx);
      end
    end
  endtask

  task automatic test_alternate();
    bit ok; int ntx, nd, nc;
    logic [1:0] exp_g;
    req_valid = '0;
    do_reset();
    req_data  = {8'h33, 8'h22, 8'h11, 8'h00};
    req_valid = 4'b0010;
    wait_event(0, 200, ok, ntx, nd, nc);
    req_valid = '0;
    wait_event(1, 200, ok, ntx, nd, nc);
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'd3 : 2'd1;
      wait_event(0, 200, ok, ntx, nd, nc);
      checks++;
      if (ok !== 1'b1 || grant_id !== exp_g || tx_data !== ((exp_g == 2'd3) ? 8'h33 : 8'h11)) begin
        errors++; $display("FAIL alt_grant%0d: seen=%b gid=%0d data=%h required gid %0d", k, ok, grant_id, tx_data, exp_g);
      end
      wait_event(1, 200, ok, ntx, nd, nc);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    bit ok; int ntx, nd, nc;
    req_valid = '0;
    do_reset();
    stub_en        = 1'b0;
    req_data       = {8'hF3, 8'h77, 8'h00, 8'h0F};
    req_valid      = 4'b0100;
    wait_event(0, 50, ok, ntx, nd, nc);
    checks++;
    if (ok !== 1'b1 || grant_id !== 2'd2) begin
      errors++; $display("FAIL timeout_grant: seen=%b gid=%0d required 1/2", ok, grant_id);
    end
    req_valid = '0;
    wait_event(2, BT + 50, ok, ntx, nd, nc);
    checks++;
    if (ok !== 1'b1 || nc !== BT + 1) begin
      errors++; $display("FAIL timeout_latency: seen=%b cycles=%0d required 1/%0d", ok, nc, BT + 1);
    end
    checks++;
    if (nd !== 0 || done !== 1'b0 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL timeout_no_done: dones=%0d done=%b busy=%b required 0/0/0", nd, done, arb_busy);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse_width: to=%b required 0", timeout_err);
    end
    stub_en   = 1'b1;
    req_valid = 4'b1001;
    wait_event(0, 50, ok, ntx, nd, nc);
    checks++;
    if (ok !== 1'b1 || grant_id !== 2'd3 || tx_data !== 8'hF3) begin
      errors++; $display("FAIL after_timeout_grant: seen=%b gid=%0d data=%h required 1/3/F3", ok, grant_id, tx_data);
    end
    req_valid = '0;
    wait_event(1, 200, ok, ntx, nd, nc);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL after_timeout_done: seen=%b required 1", ok);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int ntx, nd, nc;
    req_valid = '0;
    do_reset();
    req_data  = {8'h44, 8'h5A, 8'h11, 8'hC3};
    req_valid = 4'b0010;
    wait_event(0, 200, ok, ntx, nd, nc);
    req_valid = '0;
    wait_event(1, 200, ok, ntx, nd, nc);
    req_valid = 4'b0100;
    wait_event(0, 200, ok, ntx, nd, nc);
    req_valid = '0;
    repeat (6) @(negedge clk);
    checks++;
    if (arb_busy !== 1'b1 || tx_busy !== 1'b1) begin
      errors++; $display("FAIL mid_frame_setup: busy=%b tx_busy=%b required 1/1", arb_busy, tx_busy);
    end
    rst       = 1'b1;
    req_valid = 4'b1101;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({req_ready, tx_en, tx_data, grant_id, done, timeout_err, arb_busy} !== 18'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rdy=%b en=%b data=%h gid=%0d done=%b to=%b busy=%b required all 0",
               req_ready, tx_en, tx_data, grant_id, done, timeout_err, arb_busy);
    end
    wait_event(0, 200, ok, ntx, nd, nc);
    checks++;
    if (ok !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'hC3) begin
      errors++; $display("FAIL mid_reset_regrant: seen=%b gid=%0d data=%h required 1/0/C3", ok, grant_id, tx_data);
    end
    req_valid = '0;
    wait_event(1, 200, ok, ntx, nd, nc);
  endtask

  task automatic test_busy_block();
    bit ok; int ntx, nd, nc;
    logic [7:0] got;
    req_valid = '0;
    do_reset();
    force_busy    = 1'b1;
    req_data      = {8'h00, 8'h00, 8'h00, 8'h3C};
    req_valid     = 4'b0001;
    wait_event(0, 20, ok, ntx, nd, nc);
    checks++;
    if (ok !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL busy_block: granted=%b rdy=%b required 0/0000", ok, req_ready);
    end
    force_busy = 1'b0;
    wait_event(0, 10, ok, ntx, nd, nc);
    checks++;
    if (ok !== 1'b1 || grant_id !== 2'd0 || tx_data !== 8'h3C) begin
      errors++; $display("FAIL busy_release: seen=%b gid=%0d data=%h required 1/0/3C", ok, grant_id, tx_data);
    end
    req_valid = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (serial !== 1'b0) begin
      errors++; $display("FAIL serial_start: line=%b required 0", serial);
    end
    got = '0;
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD) @(negedge clk);
      got[i] = serial;
    end
    checks++;
    if (got !== 8'h3C) begin
      errors++; $display("FAIL serial_byte: got %h required 3C", got);
    end
    repeat (BAUD) @(negedge clk);
    checks++;
    if (serial !== 1'b1) begin
      errors++; $display("FAIL serial_stop: line=%b required 1", serial);
    end
    wait_event(1, 100, ok, ntx, nd, nc);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL serial_done: seen=%b required 1", ok);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    stub_en    = 1'b1;
    force_busy = 1'b0;
    test_reset_single();
    test_all_four();
    test_alternate();
    test_timeout();
    test_reset_mid_frame();
    test_busy_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
